// File: rtl/fmult_accum_engine.sv
// Time-shared G.726 FMULT with SEZ/SE accumulation: one (An, SRn) beat per cycle,
// three-stage pipeline (decode, product, accumulate), one tagged result per frame.
module fmult_accum_engine #(
  parameter  int NZ       = 6,
  parameter  int MAX_TAPS = 8,
  parameter  int CH_W     = 5,
  localparam int CNT_W    = $clog2(MAX_TAPS + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_an,
  input  logic [10:0]      in_sr,
  input  logic             in_last,
  input  logic [CH_W-1:0]  in_ch,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [14:0]      out_sez,
  output logic [14:0]      out_se,
  output logic [CH_W-1:0]  out_ch,
  output logic [CNT_W-1:0] out_taps,
  output logic             out_ovf
);

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

  state_t            state_q;
  logic              in_ready_q, out_valid_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ovf_q;
  logic [CH_W-1:0]   ch_q;
  logic [15:0]       sezi_q, sei_q;

  logic              s1_valid_q, s1_sign_q, s1_zero_q, s1_use_q, s1_last_q;
  logic [4:0]        s1_exp_q;
  logic [5:0]        s1_an_mant_q, s1_sr_mant_q;
  logic              s2_valid_q, s2_zero_q, s2_use_q, s2_last_q;
  logic [15:0]       s2_wan_q;
  logic              s3_last_q;

  logic              accept;
  logic [CNT_W-1:0]  beat_idx;
  logic [12:0]       an_mag;
  logic [3:0]        an_exp;
  logic [5:0]        an_mant_d;
  logic [4:0]        s1_exp_d;
  logic [7:0]        wan_mant;
  logic [14:0]       wan_base, wan_mag;
  logic [15:0]       wan_d;
  logic              unused_an_lsbs;

  assign accept         = in_valid & in_ready_q;
  assign beat_idx       = (state_q == IDLE) ? '0 : cnt_q;
  assign unused_an_lsbs = ^in_an[1:0];

  // Operand decode: An magnitude to floating point, matching the SRn format.
  always_comb begin
    an_mag = in_an[15] ? 13'(15'd16384 - {1'b0, in_an[15:2]}) : in_an[14:2];
    an_exp = '0;
    for (int i = 0; i < 13; i++) begin
      if (an_mag[i]) an_exp = 4'(i + 1);
    end
    an_mant_d = (an_mag == '0) ? 6'd32 : 6'({an_mag, 6'b0} >> an_exp);
    s1_exp_d  = {1'b0, an_exp} + {1'b0, in_sr[9:6]};
  end

  always_comb begin
    wan_mant = 8'((13'(s1_an_mant_q) * 13'(s1_sr_mant_q) + 13'd48) >> 4);
    wan_base = {wan_mant, 7'b0};
    if (s1_exp_q <= 5'd26) wan_mag = wan_base >> (5'd26 - s1_exp_q);
    else                   wan_mag = wan_base << (s1_exp_q - 5'd26);
    wan_d = s1_sign_q ? (16'd0 - {1'b0, wan_mag}) : {1'b0, wan_mag};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      ch_q         <= '0;
      sezi_q       <= '0;
      sei_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_zero_q    <= 1'b0;
      s1_use_q     <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_exp_q     <= '0;
      s1_an_mant_q <= '0;
      s1_sr_mant_q <= '0;
      s2_valid_q   <= 1'b0;
      s2_zero_q    <= 1'b0;
      s2_use_q     <= 1'b0;
      s2_last_q    <= 1'b0;
      s2_wan_q     <= '0;
      s3_last_q    <= 1'b0;
    end else if (clear) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      sezi_q      <= '0;
      sei_q       <= '0;
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s3_last_q   <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_sign_q    <= in_an[15] ^ in_sr[10];
        s1_exp_q     <= s1_exp_d;
        s1_an_mant_q <= an_mant_d;
        s1_sr_mant_q <= in_sr[5:0];
        s1_zero_q    <= beat_idx < CNT_W'(NZ);
        s1_use_q     <= beat_idx < CNT_W'(MAX_TAPS);
        s1_last_q    <= in_last;
      end
      s2_valid_q <= s1_valid_q;
      s2_zero_q  <= s1_zero_q;
      s2_use_q   <= s1_use_q;
      s2_last_q  <= s1_last_q;
      s2_wan_q   <= wan_d;
      s3_last_q  <= s2_valid_q & s2_last_q;

      // The pipeline is always empty in IDLE, so the frame-start clear never races an add.
      if (accept && state_q == IDLE) begin
        sezi_q <= '0;
        sei_q  <= '0;
        ch_q   <= in_ch;
      end else if (s2_valid_q && s2_use_q) begin
        sei_q <= sei_q + s2_wan_q;
        if (s2_zero_q) sezi_q <= sezi_q + s2_wan_q;
      end

      if (accept) begin
        if (state_q == IDLE) begin
          cnt_q <= CNT_W'(1);
          ovf_q <= 1'b0;
        end else if (cnt_q == CNT_W'(MAX_TAPS)) begin
          ovf_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end

      case (state_q)
        IDLE, ACC: begin
          in_ready_q <= 1'b1;
          if (accept && in_last) begin
            state_q    <= DRAIN;
            in_ready_q <= 1'b0;
          end else if (accept) begin
            state_q <= ACC;
          end
        end
        DRAIN: begin
          if (s3_last_q) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sez   = sezi_q[15:1];
  assign out_se    = sei_q[15:1];
  assign out_ch    = ch_q;
  assign out_taps  = cnt_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_fmult_accum_engine.sv
// Directed bench for fmult_accum_engine: table of frames with hand-computed sums,
// plus sequences for backpressure, clear in DRAIN and reset mid-frame.
module tb_fmult_accum_engine;

  logic        clk = 1'b0;
  logic        reset_n, clear, in_valid, in_last, out_ready;
  logic        in_ready, out_valid, out_ovf;
  logic [15:0] in_an;
  logic [10:0] in_sr;
  logic [4:0]  in_ch, out_ch;
  logic [14:0] out_sez, out_se;
  logic [3:0]  out_taps;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] an_z;
    logic [10:0] sr_z;
    logic [15:0] an_p;
    logic [10:0] sr_p;
    int          nb;
    logic [4:0]  ch;
    logic [14:0] sez;
    logic [14:0] se;
    logic [3:0]  taps;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  fmult_accum_engine #(.NZ(6), .MAX_TAPS(8), .CH_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_an(in_an), .in_sr(in_sr),
    .in_last(in_last), .in_ch(in_ch),
    .out_valid(out_valid), .out_ready(out_ready), .out_sez(out_sez), .out_se(out_se),
    .out_ch(out_ch), .out_taps(out_taps), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
  endtask

  // Drives n beats of v (one per cycle); in_last on beat nb-1 when with_last.
  task automatic send_beats(input vec_t v, input int n, input bit with_last);
    for (int b = 0; b < n; b++) begin
      in_valid = 1'b1;
      in_an    = (b < 6) ? v.an_z : v.an_p;
      in_sr    = (b < 6) ? v.sr_z : v.sr_p;
      in_ch    = v.ch;
      in_last  = with_last && (b == v.nb - 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_frame(input vec_t v, input int idx);
    int cyc = 0;
    wait_ready();
    send_beats(v, v.nb, 1'b1);
    while (!out_valid && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", cyc, 3);
    chk("out_sez", {17'd0, out_sez}, {17'd0, v.sez});
    chk("out_se", {17'd0, out_se}, {17'd0, v.se});
    chk("out_ch", {27'd0, out_ch}, {27'd0, v.ch});
    chk("out_taps", {28'd0, out_taps}, {28'd0, v.taps});
    chk("out_ovf", {31'd0, out_ovf}, {31'd0, v.ovf});
    $display("frame %0d: ch=%0d taps=%0d ovf=%0d sez=0x%04h se=0x%04h latency=%0d",
             idx, out_ch, out_taps, out_ovf, out_sez, out_se, cyc);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_after_release", {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  initial begin
    vecs[0] = '{16'h0000, 11'h020, 16'h0000, 11'h020,  8,  3, 15'h0000, 15'h0000, 4'd8, 1'b0};
    vecs[1] = '{16'h4000, 11'h360, 16'h0000, 11'h020,  8,  7, 15'h6480, 15'h6480, 4'd8, 1'b0};
    vecs[2] = '{16'h4000, 11'h360, 16'hC000, 11'h360,  8, 12, 15'h6480, 15'h4300, 4'd8, 1'b0};
    vecs[3] = '{16'h4000, 11'h360, 16'hC000, 11'h360, 10, 21, 15'h6480, 15'h4300, 4'd8, 1'b1};
    vecs[4] = '{16'h4000, 11'h360, 16'h0000, 11'h020,  3,  1, 15'h3240, 15'h3240, 4'd3, 1'b0};
    vecs[5] = '{16'h4000, 11'h360, 16'h0000, 11'h020,  1, 30, 15'h10C0, 15'h10C0, 4'd1, 1'b0};
    vecs[6] = '{16'h6000, 11'h360, 16'h2000, 11'h360,  8,  9, 15'h1480, 15'h2540, 4'd8, 1'b0};
    vecs[7] = '{16'h4000, 11'h3E0, 16'h4000, 11'h7E0,  8, 31, 15'h1200, 15'h0C00, 4'd8, 1'b0};

    reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_an = '0; in_sr = '0; in_ch = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {out_valid, in_ready, out_ovf, out_taps, out_ch, out_sez, out_se}, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    #1;
    chk("ready_low_after_reset", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("ready_high_after_reset", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i], i);
      release_result();
    end

    // Result held under backpressure while a competing beat is offered.
    run_frame(vecs[1], 8);
    in_valid = 1'b1; in_an = 16'h4000; in_sr = 11'h360; in_ch = 5'd2; in_last = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp_hold", {out_valid, in_ready, out_sez, out_se},
          {1'b1, 1'b0, 15'h6480, 15'h6480});
    end
    release_result();
    in_valid = 1'b0; in_last = 1'b0;
    run_frame(vecs[0], 9);
    release_result();

    // Clear while draining: no result, next frame clean.
    wait_ready();
    send_beats(vecs[1], 8, 1'b1);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    begin
      logic seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
        seen |= out_valid;
        @(posedge clk); #1;
      end
      chk("clear_no_valid", {31'd0, seen}, 32'd0);
    end
    chk("clear_ready", {31'd0, in_ready}, 32'd1);
    $display("frame aborted by clear in DRAIN");
    run_frame(vecs[2], 10);
    release_result();

    // Asynchronous reset in the middle of ACC.
    wait_ready();
    send_beats(vecs[1], 3, 1'b0);
    chk("pre_reset_taps", {28'd0, out_taps}, 32'd3);
    reset_n = 1'b0;
    #1;
    chk("midframe_reset_outputs",
        {out_valid, in_ready, out_ovf, out_taps, out_ch, out_sez, out_se}, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    #1;
    chk("ready_low_after_reset2", {31'd0, in_ready}, 32'd0);
    $display("frame aborted by reset in ACC");
    run_frame(vecs[0], 11);
    release_result();
    run_frame(vecs[6], 12);
    release_result();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
